// File: rtl/reg_bus_pkg.sv
// Shared encodings and default widths for the register-bus controllers.
package reg_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W       = 2;
  localparam int STROBE_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester ports A/B plus the register-bus side of the arbiter.
interface reg_bus_arbiter_if
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
);
  logic                  a_req, a_wr, a_ack;
  logic [BE_W-1:0]       a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata, a_rdata;

  logic                  b_req, b_wr, b_ack;
  logic [BE_W-1:0]       b_be;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata, b_rdata;

  logic                  bus_en, bus_rd, bus_wr, bus_doe, busy;
  logic [BE_W-1:0]       bus_be;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_dout, bus_din;

  // Arbiter view.
  modport master (
    input  a_req, a_wr, a_be, a_addr, a_wdata,
    input  b_req, b_wr, b_be, b_addr, b_wdata,
    input  bus_din,
    output a_ack, a_rdata, b_ack, b_rdata,
    output bus_en, bus_rd, bus_wr, bus_be, bus_addr, bus_dout, bus_doe, busy
  );

  // Requesters and register block view.
  modport slave (
    output a_req, a_wr, a_be, a_addr, a_wdata,
    output b_req, b_wr, b_be, b_addr, b_wdata,
    output bus_din,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  bus_en, bus_rd, bus_wr, bus_be, bus_addr, bus_dout, bus_doe, busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; last_grant only advances when a grant is taken.
module rr_arbiter2
  import reg_bus_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   req_a,
  input  logic   req_b,
  output logic   gnt_vld,
  output grant_e gnt
);
  grant_e last;

  // On a tie the port not served last wins; otherwise the sole requester.
  always_comb begin
    gnt_vld = req_a | req_b;
    gnt     = GRANT_A;
    if (req_a && req_b) gnt = (last == GRANT_A) ? GRANT_B : GRANT_A;
    else if (req_b)     gnt = GRANT_B;
  end

  // Remember who was served; resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset)              last <= GRANT_B;
    else if (en && gnt_vld)  last <= gnt;
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the control-register bus between host (A) and engine (B); each grant
// runs SETUP -> STROBE x N -> HOLD -> DONE with fully registered outputs.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int STROBE_CYCLES = STROBE_DEF
) (
  input logic               clk,
  input logic               reset,
  reg_bus_arbiter_if.master bif
);
  localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

  generate
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
      $error("reg_bus_arbiter: STROBE_CYCLES must be 1..15");
    end
  endgenerate

  typedef struct packed {
    logic                  wr;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e          state, nxt;
  logic [CNT_W-1:0] cnt, cnt_d;
  grant_e          gnt_q, gnt_d;
  req_t            cur, cur_d;
  logic            arb_en, arb_vld, cap;
  grant_e          arb_gnt;
  logic            en_d, doe_d;

  assign arb_en = (state == IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req_a   (bif.a_req),
    .req_b   (bif.b_req),
    .gnt_vld (arb_vld),
    .gnt     (arb_gnt)
  );

  // Next state, strobe counter and latched request fields.
  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    gnt_d = gnt_q;
    cur_d = cur;
    unique case (state)
      IDLE: if (arb_vld) begin
        gnt_d = arb_gnt;
        cur_d = (arb_gnt == GRANT_A) ?
                req_t'{wr: bif.a_wr, be: bif.a_be, addr: bif.a_addr, wdata: bif.a_wdata} :
                req_t'{wr: bif.b_wr, be: bif.b_be, addr: bif.b_addr, wdata: bif.b_wdata};
        nxt   = SETUP;
      end
      SETUP: begin
        cnt_d = CNT_W'(STROBE_CYCLES);
        nxt   = STROBE;
      end
      STROBE: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) nxt = HOLD;
      end
      HOLD:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus drive for the coming cycle is derived from the next state so the
  // outputs themselves are flops; write data stays up through HOLD.
  assign en_d  = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);
  assign doe_d = en_d && cur_d.wr;
  // Read data is sampled on the final strobe cycle.
  assign cap   = (state == STROBE) && (cnt == CNT_W'(1)) && !cur.wr;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt_q        <= GRANT_B;
      cur          <= '0;
      bif.bus_en   <= 1'b0;
      bif.bus_rd   <= 1'b0;
      bif.bus_wr   <= 1'b0;
      bif.bus_doe  <= 1'b0;
      bif.bus_be   <= '0;
      bif.bus_addr <= '0;
      bif.bus_dout <= '0;
      bif.busy     <= 1'b0;
      bif.a_ack    <= 1'b0;
      bif.b_ack    <= 1'b0;
      bif.a_rdata  <= '0;
      bif.b_rdata  <= '0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_d;
      gnt_q        <= gnt_d;
      cur          <= cur_d;
      bif.bus_en   <= en_d;
      bif.bus_rd   <= (nxt == STROBE) && !cur_d.wr;
      bif.bus_wr   <= (nxt == STROBE) && cur_d.wr;
      bif.bus_doe  <= doe_d;
      bif.bus_be   <= en_d  ? cur_d.be    : '0;
      bif.bus_addr <= en_d  ? cur_d.addr  : '0;
      bif.bus_dout <= doe_d ? cur_d.wdata : '0;
      bif.busy     <= (nxt != IDLE);
      bif.a_ack    <= (nxt == DONE) && (gnt_d == GRANT_A);
      bif.b_ack    <= (nxt == DONE) && (gnt_d == GRANT_B);
      if (cap && gnt_q == GRANT_A) bif.a_rdata <= bif.bus_din;
      if (cap && gnt_q == GRANT_B) bif.b_rdata <= bif.bus_din;
    end
  end
endmodule
